// File: rtl/player_motion_if.sv
// Button/hit inputs and pose/coordinate outputs exchanged between the input
// decoder, the movement controller and the renderer/collision logic.
interface player_motion_if #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int VW = 7
);
  logic                 tick;
  logic                 right;
  logic                 left;
  logic                 jump;
  logic                 squat;
  logic                 defend;
  logic                 hit;
  logic                 hit_dir;
  logic signed [XW-1:0] x;
  logic signed [YW-1:0] y;
  logic signed [VW-1:0] vy;
  logic [1:0]           state;
  logic                 isD;
  logic                 isQ;
  logic                 isJ;
  logic                 isStun;

  modport master (
    output tick, right, left, jump, squat, defend, hit, hit_dir,
    input  x, y, vy, state, isD, isQ, isJ, isStun
  );

  modport slave (
    input  tick, right, left, jump, squat, defend, hit, hit_dir,
    output x, y, vy, state, isD, isQ, isJ, isStun
  );
endinterface

// File: rtl/player_motion.sv
// Per-player movement/physics controller: walking, multi-jump with gravity,
// guard and hit-stun with knockback. All state advances only on tick.
module player_motion #(
  parameter int XW          = 11,
  parameter int YW          = 10,
  parameter int VW          = 7,
  parameter int X_MIN       = 16,
  parameter int X_MAX       = 600,
  parameter int X_INIT      = 100,
  parameter int GROUND_Y    = -200,
  parameter int STEP_X      = 4,
  parameter int JUMP_V      = 12,
  parameter int GRAV        = 1,
  parameter int VY_MAX_FALL = 15,
  parameter int AIR_JUMPS   = 1,
  parameter int KB_X        = 6,
  parameter int KB_V        = 8,
  parameter int STUN_TICKS  = 20
) (
  input logic            clk,
  input logic            rst_n,
  player_motion_if.slave bus
);
  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_STUN   = 2'd2
  } state_t;

  localparam int SW       = $clog2(STUN_TICKS + 1);
  localparam int AW       = (AIR_JUMPS > 0) ? $clog2(AIR_JUMPS + 1) : 1;
  localparam int KB_H     = KB_X / 2;
  localparam int FALL_NEG = -VY_MAX_FALL;

  localparam logic signed [XW:0]   X_MIN_E  = X_MIN[XW:0];
  localparam logic signed [XW:0]   X_MAX_E  = X_MAX[XW:0];
  localparam logic signed [XW-1:0] X_MIN_V  = X_MIN[XW-1:0];
  localparam logic signed [XW-1:0] X_MAX_V  = X_MAX[XW-1:0];
  localparam logic signed [XW-1:0] X_INIT_V = X_INIT[XW-1:0];
  localparam logic signed [XW:0]   STEP_E   = STEP_X[XW:0];
  localparam logic signed [XW:0]   KB_E     = KB_X[XW:0];
  localparam logic signed [XW:0]   KB_H_E   = KB_H[XW:0];
  localparam logic signed [YW:0]   GROUND_E = GROUND_Y[YW:0];
  localparam logic signed [YW-1:0] GROUND_V = GROUND_Y[YW-1:0];
  localparam logic signed [VW:0]   GRAV_E   = GRAV[VW:0];
  localparam logic signed [VW:0]   FALL_E   = FALL_NEG[VW:0];
  localparam logic signed [VW-1:0] FALL_V   = FALL_NEG[VW-1:0];
  localparam logic signed [VW-1:0] JUMP_V_V = JUMP_V[VW-1:0];
  localparam logic signed [VW-1:0] KB_V_V   = KB_V[VW-1:0];
  localparam logic [SW-1:0]        STUN_V   = STUN_TICKS[SW-1:0];
  localparam logic [AW-1:0]        AIRJ_V   = AIR_JUMPS[AW-1:0];

  function automatic logic signed [XW-1:0] clamp_x(input logic signed [XW:0] v);
    if (v < X_MIN_E) begin
      return X_MIN_V;
    end else if (v > X_MAX_E) begin
      return X_MAX_V;
    end else begin
      return v[XW-1:0];
    end
  endfunction

  state_t                state_r, state_n_s;
  logic signed [XW-1:0]  x_r, x_n_s;
  logic signed [YW-1:0]  y_r, y_n_s;
  logic signed [VW-1:0]  vy_r, vy_n_s;
  logic [SW-1:0]         stun_cnt_r, stun_cnt_n_s, cnt_dec_s;
  logic [AW-1:0]         air_left_r, air_left_n_s;
  logic                  jump_prev_r, jump_prev_n_s;
  logic                  kb_dir_r, kb_dir_n_s;
  logic                  jump_edge_s, land_s;
  logic signed [XW:0]    x_ext_s, move_s, kb_s;
  logic signed [YW:0]    y_sum_s;
  logic signed [VW:0]    vy_dec_s;
  logic signed [VW-1:0]  vy_fall_s;

  assign jump_edge_s = bus.jump & ~jump_prev_r;
  assign x_ext_s     = {x_r[XW-1], x_r};
  assign kb_s        = kb_dir_r ? KB_E : -KB_E;
  assign y_sum_s     = {y_r[YW-1], y_r} + {{(YW + 1 - VW){vy_r[VW-1]}}, vy_r};
  assign vy_dec_s    = {vy_r[VW-1], vy_r} - GRAV_E;
  assign vy_fall_s   = (vy_dec_s < FALL_E) ? FALL_V : vy_dec_s[VW-1:0];
  assign land_s      = (y_sum_s <= GROUND_E);
  assign cnt_dec_s   = (stun_cnt_r == {SW{1'b0}}) ? {SW{1'b0}}
                                                  : stun_cnt_r - {{(SW-1){1'b0}}, 1'b1};

  // Walk direction: opposing buttons cancel.
  always_comb begin
    if (bus.right && !bus.left) begin
      move_s = STEP_E;
    end else if (bus.left && !bus.right) begin
      move_s = -STEP_E;
    end else begin
      move_s = {(XW+1){1'b0}};
    end
  end

  // Next-state and datapath update for one frame tick.
  always_comb begin
    state_n_s     = state_r;
    x_n_s         = x_r;
    y_n_s         = y_r;
    vy_n_s        = vy_r;
    stun_cnt_n_s  = stun_cnt_r;
    air_left_n_s  = air_left_r;
    jump_prev_n_s = jump_prev_r;
    kb_dir_n_s    = kb_dir_r;
    if (bus.tick) begin
      jump_prev_n_s = bus.jump;
      case (state_r)
        ST_GROUND: begin
          if (bus.hit && !bus.defend) begin
            state_n_s    = ST_STUN;
            stun_cnt_n_s = STUN_V;
            vy_n_s       = KB_V_V;
            kb_dir_n_s   = bus.hit_dir;
          end else if (bus.hit) begin
            x_n_s = clamp_x(x_ext_s + (bus.hit_dir ? KB_H_E : -KB_H_E));
          end else if (bus.defend || bus.squat) begin
            x_n_s = x_r;
          end else if (jump_edge_s) begin
            state_n_s    = ST_AIR;
            vy_n_s       = JUMP_V_V;
            air_left_n_s = AIRJ_V;
            x_n_s        = clamp_x(x_ext_s + move_s);
          end else begin
            x_n_s = clamp_x(x_ext_s + move_s);
          end
        end
        ST_AIR: begin
          if (bus.hit) begin
            state_n_s    = ST_STUN;
            stun_cnt_n_s = STUN_V;
            vy_n_s       = KB_V_V;
            kb_dir_n_s   = bus.hit_dir;
          end else begin
            // An air jump freezes y for this tick; otherwise integrate and land.
            if (jump_edge_s && (air_left_r != {AW{1'b0}})) begin
              vy_n_s       = JUMP_V_V;
              air_left_n_s = air_left_r - {{(AW-1){1'b0}}, 1'b1};
            end else if (land_s) begin
              y_n_s     = GROUND_V;
              vy_n_s    = {VW{1'b0}};
              state_n_s = ST_GROUND;
            end else begin
              y_n_s  = y_sum_s[YW-1:0];
              vy_n_s = vy_fall_s;
            end
            x_n_s = clamp_x(x_ext_s + move_s);
          end
        end
        ST_STUN: begin
          x_n_s        = clamp_x(x_ext_s + kb_s);
          stun_cnt_n_s = cnt_dec_s;
          if (land_s) begin
            y_n_s  = GROUND_V;
            vy_n_s = {VW{1'b0}};
          end else begin
            y_n_s  = y_sum_s[YW-1:0];
            vy_n_s = vy_fall_s;
          end
          if (cnt_dec_s == {SW{1'b0}}) begin
            state_n_s    = land_s ? ST_GROUND : ST_AIR;
            air_left_n_s = {AW{1'b0}};
          end else begin
            state_n_s = ST_STUN;
          end
        end
        default: begin
          state_n_s = ST_GROUND;
        end
      endcase
    end else begin
      jump_prev_n_s = jump_prev_r;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_GROUND;
      x_r         <= X_INIT_V;
      y_r         <= GROUND_V;
      vy_r        <= {VW{1'b0}};
      stun_cnt_r  <= {SW{1'b0}};
      air_left_r  <= {AW{1'b0}};
      jump_prev_r <= 1'b0;
      kb_dir_r    <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      x_r         <= x_n_s;
      y_r         <= y_n_s;
      vy_r        <= vy_n_s;
      stun_cnt_r  <= stun_cnt_n_s;
      air_left_r  <= air_left_n_s;
      jump_prev_r <= jump_prev_n_s;
      kb_dir_r    <= kb_dir_n_s;
    end
  end

  assign bus.x      = x_r;
  assign bus.y      = y_r;
  assign bus.vy     = vy_r;
  assign bus.state  = state_r;
  assign bus.isD    = bus.defend & (state_r == ST_GROUND);
  assign bus.isQ    = bus.squat & ~bus.defend & (state_r == ST_GROUND);
  assign bus.isJ    = (state_r == ST_AIR);
  assign bus.isStun = (state_r == ST_STUN);
endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: ground-move vector table plus hand-written
// jump, fall-cap, stun and asynchronous-reset sequences.
module tb_player_motion;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  player_motion_if #(.XW(11), .YW(10), .VW(7)) bus ();

  player_motion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r, l, j, sq, d, h, hd;
    int   n;
    int   ex;
    int   est;
    logic ed, eq;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.tick = 1'b0;
  endtask

  task automatic set_in(input logic r, l, j, sq, d, h, hd);
    bus.right = r; bus.left = l; bus.jump = j; bus.squat = sq;
    bus.defend = d; bus.hit = h; bus.hit_dir = hd;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int min_vy;
    int ticks;
    logic landed;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // x, state, isD, isQ expected after n ticks; y stays on the floor throughout
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,   1,  97, 0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,   1, 100, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,   1, 103, 0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,   1, 106, 0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,   1, 106, 0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,   1, 106, 0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,   3, 106, 0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,   1, 102, 0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,   1, 106, 0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 123, 598, 0, 1'b0, 1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,   1, 600, 0, 1'b0, 1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,   1, 600, 0, 1'b0, 1'b0};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,   1, 596, 0, 1'b0, 1'b0};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,   2, 596, 0, 1'b0, 1'b0};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 145,  16, 0, 1'b0, 1'b0};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,   1,  16, 0, 1'b0, 1'b0};
    tbl[16] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,   1,  16, 0, 1'b0, 1'b1};
    tbl[17] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,   1,  16, 0, 1'b0, 1'b0};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,   1,  16, 0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_x", bus.x, 100);
    check("reset_y", bus.y, -200);
    check("reset_vy", bus.vy, 0);
    check("reset_state", bus.state, 0);
    check("reset_isJ", bus.isJ, 0);
    rst_n = 1'b1;

    // Jump held through reset release counts as an edge.
    step(1);
    check("jump_state", bus.state, 1);
    check("jump_vy", bus.vy, 12);
    check("jump_y", bus.y, -200);
    check("jump_isJ", bus.isJ, 1);
    bus.jump = 1'b0;
    step(12);
    check("apex_y", bus.y, -122);
    check("apex_vy", bus.vy, 0);
    step(12);
    check("pre_land_y", bus.y, -188);
    check("pre_land_state", bus.state, 1);
    step(1);
    check("land_y", bus.y, -200);
    check("land_vy", bus.vy, 0);
    check("land_state", bus.state, 0);
    check("land_x", bus.x, 100);

    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].r, tbl[i].l, tbl[i].j, tbl[i].sq, tbl[i].d, tbl[i].h, tbl[i].hd);
      step(tbl[i].n);
      check($sformatf("vec%0d_x", i), bus.x, tbl[i].ex);
      check($sformatf("vec%0d_y", i), bus.y, -200);
      check($sformatf("vec%0d_state", i), bus.state, tbl[i].est);
      check($sformatf("vec%0d_isD", i), bus.isD, tbl[i].ed);
      check($sformatf("vec%0d_isQ", i), bus.isQ, tbl[i].eq);
    end

    // No tick: nothing moves.
    bus.right = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_tick_x", bus.x, 16);
    bus.right = 1'b0;

    // Double jump at apex, third edge ignored, then capped fall.
    bus.jump = 1'b1;
    step(1);
    check("dj1_vy", bus.vy, 12);
    bus.jump = 1'b0;
    step(12);
    check("dj_apex_y", bus.y, -122);
    bus.jump = 1'b1;
    step(1);
    check("dj2_vy", bus.vy, 12);
    check("dj2_y", bus.y, -122);
    check("dj2_state", bus.state, 1);
    bus.jump = 1'b0;
    step(6);
    check("dj_mid_y", bus.y, -65);
    check("dj_mid_vy", bus.vy, 6);
    bus.jump = 1'b1;
    step(1);
    check("dj3_ignored_vy", bus.vy, 5);
    check("dj3_ignored_y", bus.y, -59);
    bus.jump = 1'b0;
    min_vy = 0;
    ticks  = 0;
    landed = 1'b0;
    for (int k = 0; k < 60 && !landed; k++) begin
      step(1);
      ticks++;
      if (int'(bus.vy) < min_vy) min_vy = bus.vy;
      if (bus.state == 2'd0) landed = 1'b1;
    end
    check("fall_landed", landed, 1);
    check("fall_ticks", ticks, 24);
    check("fall_min_vy", min_vy, -15);
    check("fall_land_y", bus.y, -200);
    check("fall_land_vy", bus.vy, 0);

    // Unguarded ground hit and 20 stun ticks with buttons mashed.
    bus.right = 1'b1;
    step(21);
    check("pre_hit_x", bus.x, 100);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    check("hit_state", bus.state, 2);
    check("hit_vy", bus.vy, 8);
    check("hit_y", bus.y, -200);
    check("hit_x", bus.x, 100);
    check("hit_isStun", bus.isStun, 1);
    for (int k = 1; k <= 20; k++) begin
      set_in(1'b0, 1'b1, k[0], 1'b1, 1'b1, 1'b1, 1'b0);
      step(1);
      check($sformatf("stun%0d_x", k), bus.x, 100 + 6 * k);
      check($sformatf("stun%0d_state", k), bus.state, (k < 20) ? 2 : 0);
      if (k == 16) check("stun16_y", bus.y, -192);
      if (k == 17) begin
        check("stun17_y", bus.y, -200);
        check("stun17_vy", bus.vy, 0);
      end
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hit and jump edge together: hit wins; then reset mid-stun.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    check("hitjump_state", bus.state, 2);
    check("hitjump_vy", bus.vy, 8);
    bus.hit = 1'b0;
    step(2);
    check("stun_left_x", bus.x, 208);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", bus.x, 100);
    check("async_rst_y", bus.y, -200);
    check("async_rst_vy", bus.vy, 0);
    check("async_rst_state", bus.state, 0);
    check("async_rst_isStun", bus.isStun, 0);
    bus.jump = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
    check("post_rst_state", bus.state, 0);
    check("post_rst_x", bus.x, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/player_motion.md
Name: player_motion

Overview:
- Parametrised per-player movement and physics controller, the next generation of the fighter movement block.
- Advances position only on a frame-rate `tick`, not every `clk`.
- Jumping uses velocity integration with gravity and a fall-speed cap, with a configurable number of air jumps. It adds hit/knockback handling with a stun timer and a ground-only guard.
- Sits between the input decoder and the renderer/collision logic: consumes button levels and hit events, drives coordinates and pose flags.

Parameters:
- XW, 11, signed x coordinate width
- YW, 10, signed y coordinate width (y positive = up)
- VW, 7, signed vertical velocity width
- X_MIN, 16, left clamp bound
- X_MAX, 600, right clamp bound
- X_INIT, 100, x after reset
- GROUND_Y, -200, floor y value
- STEP_X, 4, walk step per tick
- JUMP_V, 12, vy loaded on any jump
- GRAV, 1, vy decrement per airborne tick
- VY_MAX_FALL, 15, magnitude cap on downward vy
- AIR_JUMPS, 1, extra jumps allowed per airborne period
- KB_X, 6, knockback x per stun tick; KB_X/2 pushback when guarding
- KB_V, 8, vy loaded on an unguarded hit
- STUN_TICKS, 20, stun duration in ticks

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- tick  in  1  frame update strobe; state changes only when tick=1
- right  in  1  move right (level)
- left  in  1  move left (level)
- jump  in  1  jump button (level; rising edge acts)
- squat  in  1  squat (level)
- defend  in  1  guard (level)
- hit  in  1  hit event, sampled on tick
- hit_dir  in  1  1 = push toward +x, 0 = toward -x
- x  out  XW  signed position
- y  out  YW  signed position
- vy  out  VW  signed vertical velocity
- state  out  2  0 = GROUND, 1 = AIR, 2 = STUN
- isD  out  1  guarding
- isQ  out  1  squatting
- isJ  out  1  airborne, not stunned
- isStun  out  1  stunned

Behaviour:
- Reset values: x=X_INIT, y=GROUND_Y, vy=0, state=GROUND, stun_cnt=0, air_left=0, jump_prev=0. Reset is async and valid mid-jump or mid-stun.
- All registers hold when tick=0. jump_prev updates only on tick. jump_edge = jump & ~jump_prev. A jump held through reset release counts as an edge on the first tick.
- Horizontal input: dir = +1 if right&~left, -1 if left&~right, 0 if both or neither.
- x arithmetic uses XW+1 bits, then clamps to [X_MIN, X_MAX]. This applies after every update, including knockback.
- y and vy arithmetic uses YW+1 / VW+1 bits.
- Outputs are registered, except the flags:
  - isD = defend & state==GROUND
  - isQ = squat & ~defend & state==GROUND
  - isJ = state==AIR
  - isStun = state==STUN
- GROUND, one tick, priority hit > defend > squat > jump_edge > move:
  - hit & ~defend: state=STUN, stun_cnt=STUN_TICKS, vy=KB_V, y unchanged.
  - hit & defend: x += ±KB_X/2 per hit_dir; stays GROUND.
  - defend or squat: no x move, no jump.
  - jump_edge: state=AIR, vy=JUMP_V, air_left=AIR_JUMPS, y unchanged, x += dir*STEP_X.
  - otherwise: x += dir*STEP_X.
- AIR, one tick:
  - If hit: go to STUN exactly as on the ground; defend is ignored in air.
  - Otherwise:
    - If jump_edge & air_left>0: vy=JUMP_V, air_left−1, y unchanged this tick.
    - Else: y_n = y+vy and vy_n = max(vy−GRAV, −VY_MAX_FALL).
    - If y_n <= GROUND_Y: y=GROUND_Y, vy=0, state=GROUND on the same tick.
    - x += dir*STEP_X.
- STUN, one tick:
  - Ignores all buttons and further hits; no re-stun or stacking.
  - x += ±KB_X per hit_dir latched at hit entry.
  - y/vy integrate as in AIR. Landing sets y=GROUND_Y, vy=0 and stays in STUN.
  - stun_cnt−1. When stun_cnt reaches 0:
    - at GROUND_Y → GROUND
    - else → AIR with air_left=0
- Simultaneous hit and jump_edge: hit wins; the jump is consumed (jump_prev updated).

Test Plan:
- Reset, then jump edge on tick 1 → state=AIR, vy=12, y=−200. After 12 more ticks y=−122, vy=0. Lands y=−200, vy=0, state=GROUND on the 25th airborne tick.
- x=598, right held 2 ticks → x=600, 600. left&right both held → x unchanged. tick=0 with right held for 10 clks → no change.
- Jump, then second jump edge at apex (y=−122) → vy=12 reloads. Third edge mid-air → ignored (air_left=0).
- Long fall from double-jump peak → vy saturates at −15, never below.
- Ground, hit with hit_dir=1 at x=100 → STUN, vy=8. x +6 per tick (106, 112, …). Buttons ignored. GROUND after 20 ticks once landed.
- defend=1 with hit, hit_dir=0 at x=100 → x=97, state stays GROUND, isD=1. Assert rst_n low mid-stun → all reset values immediately, without a clk edge.
